shift_seq_unit: RTL and testbench

//  Multi-cycle RV32 shift unit (SLL/SRL/SRA) for the ALU's slow-op path.

---
 rtl/shift_pkg.sv | 43 ++++
 rtl/decode_dif.sv | 17 +
 rtl/shift_seq_unit.sv | 149 ++++++++++++++
 tb/tb_shift_seq_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and helpers for the sequential RV32 shift unit.
package shift_pkg;

  localparam int XLEN = 32;
  localparam int SHW  = 5;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_RSV = 2'b10,
    SH_SRA = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Index of the highest set bit; 0 when no bit is set.
  function automatic logic [2:0] msb_idx(input logic [SHW-1:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < SHW; i++) begin
      if (v[i]) begin
        r = 3'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic logic [XLEN-1:0] bitrev(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r = '0;
    for (int i = 0; i < XLEN; i++) begin
      r[i] = v[XLEN-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/decode_dif.sv
// Thermometer decoder: mask_o[i] is set exactly when i < shamt_i.
module decode_dif
  import shift_pkg::*;
(
  input  logic [SHW-1:0]  shamt_i,
  output logic [XLEN-1:0] mask_o
);

  // Compare every bit position against the shift amount.
  always_comb begin
    mask_o = '0;
    for (int i = 0; i < XLEN; i++) begin
      mask_o[i] = (5'(i) < shamt_i);
    end
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle SLL/SRL/SRA unit: one shamt bit per cycle, valid/ready on both sides.
module shift_seq_unit
  import shift_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [1:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [4:0]  shamt_i,
  input  logic        kill_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic        busy_o
);

  state_e            state_r, state_next_s;
  shift_op_e         op_r, op_next_s;
  logic [XLEN-1:0]   data_r, data_next_s;
  logic [XLEN-1:0]   result_r, result_next_s;
  logic [SHW-1:0]    shamt_r, shamt_next_s;
  logic [2:0]        k_r, k_next_s;
  logic              sign_r, sign_next_s;
  logic              valid_r, valid_next_s;

  logic              ready_s;
  logic [4:0]        amt_s;
  logic [XLEN-1:0]   shifted_s;
  logic [XLEN-1:0]   mask_s;
  logic [XLEN-1:0]   fill_s;
  logic              last_s;
  logic              short_s;

  decode_dif u_decode_dif (
    .shamt_i (shamt_r),
    .mask_o  (mask_s)
  );

  assign ready_s  = (state_r == ST_IDLE) && !rst_i && !kill_i;
  assign ready_o  = ready_s;
  assign valid_o  = valid_r;
  assign result_o = result_r;
  assign busy_o   = (state_r != ST_IDLE);

  // Datapath for the current step plus exit conditions.
  always_comb begin
    amt_s   = shamt_r[k_r] ? (5'd1 << k_r) : 5'd0;
    last_s  = EARLY_EXIT ? (k_r == msb_idx(shamt_r)) : (k_r == 3'd4);
    short_s = (op_r == SH_RSV) || (EARLY_EXIT && (shamt_r == 5'd0));
    case (op_r)
      SH_SLL:  shifted_s = data_r << amt_s;
      SH_SRL:  shifted_s = data_r >> amt_s;
      SH_SRA:  shifted_s = data_r >> amt_s;
      default: shifted_s = data_r;
    endcase
    // The arithmetic fill is the top shamt bits, applied once at the end.
    if ((op_r == SH_SRA) && sign_r) begin
      fill_s = bitrev(mask_s);
    end else begin
      fill_s = 32'd0;
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    state_next_s  = state_r;
    op_next_s     = op_r;
    data_next_s   = data_r;
    shamt_next_s  = shamt_r;
    sign_next_s   = sign_r;
    k_next_s      = k_r;
    result_next_s = result_r;
    valid_next_s  = valid_r;
    case (state_r)
      ST_IDLE: begin
        if (valid_i && ready_s) begin
          op_next_s    = shift_op_e'(op_i);
          data_next_s  = rs1_i;
          shamt_next_s = shamt_i;
          sign_next_s  = rs1_i[31];
          k_next_s     = 3'd0;
          state_next_s = ST_SHIFT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (kill_i) begin
          state_next_s = ST_IDLE;
          valid_next_s = 1'b0;
        end else if (short_s) begin
          result_next_s = data_r;
          valid_next_s  = 1'b1;
          state_next_s  = ST_DONE;
        end else begin
          data_next_s = shifted_s;
          k_next_s    = k_r + 3'd1;
          if (last_s) begin
            result_next_s = shifted_s | fill_s;
            valid_next_s  = 1'b1;
            state_next_s  = ST_DONE;
          end else begin
            state_next_s = ST_SHIFT;
          end
        end
      end
      ST_DONE: begin
        if (kill_i || ready_i) begin
          state_next_s = ST_IDLE;
          valid_next_s = 1'b0;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        valid_next_s = 1'b0;
      end
    endcase
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      op_r     <= SH_SLL;
      data_r   <= 32'd0;
      shamt_r  <= 5'd0;
      sign_r   <= 1'b0;
      k_r      <= 3'd0;
      result_r <= 32'd0;
      valid_r  <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      op_r     <= op_next_s;
      data_r   <= data_next_s;
      shamt_r  <= shamt_next_s;
      sign_r   <= sign_next_s;
      k_r      <= k_next_s;
      result_r <= result_next_s;
      valid_r  <= valid_next_s;
    end
  end

endmodule

// File: tb/tb_shift_seq_unit.sv
// Directed test of shift_seq_unit; u_dut0 uses early exit, u_dut1 always runs 5 steps.
module tb_shift_seq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid0, valid1;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [4:0]  shamt;
  logic        kill;
  logic        rdy_in;
  logic        rdy0, rdy1, vo0, vo1, busy0, busy1;
  logic [31:0] res0, res1;

  int checks = 0;
  int errors = 0;
  int lat;

  always #5 clk = ~clk;

  shift_seq_unit #(.EARLY_EXIT(1'b1)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid0), .ready_o(rdy0), .op_i(op),
    .rs1_i(rs1), .shamt_i(shamt), .kill_i(kill), .valid_o(vo0),
    .ready_i(rdy_in), .result_o(res0), .busy_o(busy0)
  );

  shift_seq_unit #(.EARLY_EXIT(1'b0)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid1), .ready_o(rdy1), .op_i(op),
    .rs1_i(rs1), .shamt_i(shamt), .kill_i(kill), .valid_o(vo1),
    .ready_i(rdy_in), .result_o(res1), .busy_o(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic start(input bit sel, input logic [1:0] o, input logic [31:0] a, input logic [4:0] s);
    @(negedge clk);
    op = o; rs1 = a; shamt = s;
    if (sel) valid1 = 1'b1;
    else     valid0 = 1'b1;
    #1;
    check("ready_before_accept", sel ? rdy1 : rdy0, 32'd1);
    @(posedge clk);
    #1;
    valid0 = 1'b0;
    valid1 = 1'b0;
  endtask

  task automatic wait_done(input bit sel, output int l);
    bit seen;
    seen = 1'b0;
    l = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      l++;
      if ((sel ? vo1 : vo0) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_ok(input bit sel);
    @(posedge clk);
    #1;
    check("valid_cleared", sel ? vo1 : vo0, 32'd0);
    check("ready_after_done", sel ? rdy1 : rdy0, 32'd1);
  endtask

  initial begin
    bit vseen;
    rst = 1'b1; valid0 = 1'b0; valid1 = 1'b0; op = 2'b00; rs1 = 32'd0;
    shamt = 5'd0; kill = 1'b0; rdy_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", vo0, 32'd0);
    check("rst_result", res0, 32'd0);
    check("rst_busy", busy0, 32'd0);
    check("rst_ready", rdy0, 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", rdy0, 32'd1);

    // SLL by 31: all five steps needed
    start(1'b0, 2'b00, 32'h0000_0001, 5'd31);
    wait_done(1'b0, lat);
    check("sll31_lat", lat, 32'd5);
    check("sll31_res", res0, 32'h8000_0000);
    check("sll31_ready_low", rdy0, 32'd0);
    finish_ok(1'b0);

    start(1'b0, 2'b11, 32'h8000_0000, 5'd4);
    wait_done(1'b0, lat);
    check("sra4_neg_lat", lat, 32'd3);
    check("sra4_neg_res", res0, 32'hF800_0000);
    finish_ok(1'b0);

    start(1'b0, 2'b11, 32'h7000_0000, 5'd4);
    wait_done(1'b0, lat);
    check("sra4_pos_lat", lat, 32'd3);
    check("sra4_pos_res", res0, 32'h0700_0000);
    finish_ok(1'b0);

    start(1'b0, 2'b01, 32'hFFFF_FFFF, 5'd0);
    wait_done(1'b0, lat);
    check("srl0_ee_lat", lat, 32'd1);
    check("srl0_ee_res", res0, 32'hFFFF_FFFF);
    finish_ok(1'b0);

    start(1'b1, 2'b01, 32'hFFFF_FFFF, 5'd0);
    wait_done(1'b1, lat);
    check("srl0_full_lat", lat, 32'd5);
    check("srl0_full_res", res1, 32'hFFFF_FFFF);
    finish_ok(1'b1);

    // Backpressure: result must hold while the consumer stalls
    rdy_in = 1'b0;
    start(1'b0, 2'b11, 32'hF000_000F, 5'd8);
    wait_done(1'b0, lat);
    check("bp_lat", lat, 32'd4);
    check("bp_res", res0, 32'hFFF0_0000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", vo0, 32'd1);
      check("bp_hold_res", res0, 32'hFFF0_0000);
      check("bp_hold_ready", rdy0, 32'd0);
    end
    rdy_in = 1'b1;
    @(posedge clk);
    #1;
    check("bp_rel_valid", vo0, 32'd0);
    check("bp_rel_busy", busy0, 32'd0);
    check("bp_rel_ready", rdy0, 32'd1);

    // Kill two cycles into a long shift
    start(1'b0, 2'b00, 32'h0000_0001, 5'd31);
    vseen = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (vo0) vseen = 1'b1;
    end
    kill = 1'b1;
    #1;
    check("kill_ready_busy", rdy0, 32'd0);
    @(posedge clk);
    #1;
    check("kill_busy", busy0, 32'd0);
    check("kill_ready_gated", rdy0, 32'd0);
    kill = 1'b0;
    #1;
    check("kill_ready", rdy0, 32'd1);
    repeat (6) begin
      @(posedge clk);
      #1;
      if (vo0) vseen = 1'b1;
    end
    check("kill_no_valid", vseen, 32'd0);

    start(1'b0, 2'b01, 32'h0000_0100, 5'd8);
    wait_done(1'b0, lat);
    check("srl8_lat", lat, 32'd4);
    check("srl8_res", res0, 32'h0000_0001);
    finish_ok(1'b0);

    // Reset in the middle of a shift
    start(1'b0, 2'b00, 32'h0000_0001, 5'd31);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_ready_comb", rdy0, 32'd0);
    @(posedge clk);
    #1;
    check("midrst_valid", vo0, 32'd0);
    check("midrst_result", res0, 32'd0);
    check("midrst_busy", busy0, 32'd0);
    check("midrst_ready", rdy0, 32'd0);
    rst = 1'b0;
    #1;
    check("midrst_ready_after", rdy0, 32'd1);

    start(1'b0, 2'b10, 32'h1234_5678, 5'd7);
    wait_done(1'b0, lat);
    check("rsv_lat", lat, 32'd1);
    check("rsv_res", res0, 32'h1234_5678);
    finish_ok(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
